// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state encoding and default sizes for the register-file execute stage.
// Imported by the interface, the multiplier and the top-level unit.
package exec_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AW_DEF    = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_MUL = 3'd6,
        OP_RSV = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_exec_unit_if.sv
// Request (operands/opcode/dest) and write-back bus between the register file and the execute unit.
// The master is the register-file side; the slave is the execute unit.
interface regfile_exec_unit_if
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic [AW-1:0]    dest;
    logic             wb_write;
    logic [AW-1:0]    wb_address;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output in_valid, op, value1, value2, dest,
        input  in_ready, wb_write, wb_address, wb_data
    );

    modport slave (
        input  in_valid, op, value1, value2, dest,
        output in_ready, wb_write, wb_address, wb_data
    );

endinterface

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier: one partial product per clock after start, done on the last step.
// product is the accumulator value after the current iteration, so it is final in the done cycle.
module exec_mul_seq #(
    parameter int WIDTH = 16,
    parameter int STEPS = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      step;
    logic               active;
    logic [2*WIDTH-1:0] addend;

    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = active && (step == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            step   <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            step   <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                step   <= '0;
                active <= 1'b0;
            end else begin
                step   <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_exec_unit.sv
// Execute stage behind the register file read ports: single-cycle ALU ops, multi-cycle multiply.
// Multiply is only built when EXEC_MUL_EN is defined; otherwise opcode 6 is treated as reserved.
module regfile_exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int AW        = AW_DEF,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_exec_unit_if.slave   bus,
    output logic                 busy,
    output logic                 flag_zero,
    output logic                 flag_carry
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             alu_load;
    logic             mul_load;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH:0]   alu_res;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        alu_res = '0;
        case (opcode_t'(bus.op))
            OP_ADD:  alu_res = {1'b0, bus.value1} + {1'b0, bus.value2};
            OP_SUB:  alu_res = {1'b0, bus.value1} + {1'b0, ~bus.value2} + (WIDTH+1)'(1);
            OP_AND:  alu_res = {1'b0, bus.value1 & bus.value2};
            OP_OR:   alu_res = {1'b0, bus.value1 | bus.value2};
            OP_XOR:  alu_res = {1'b0, bus.value1 ^ bus.value2};
            OP_SHL:  alu_res = {1'b0, bus.value1 << bus.value2[3:0]};
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [2*WIDTH-1:0] mul_product;
    logic [AW-1:0]      dest_q;

    exec_mul_seq #(
        .WIDTH (WIDTH),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.value1),
        .b       (bus.value2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_q <= '0;
        end else if (mul_start) begin
            dest_q <= bus.dest;
        end
    end
`else
    assign mul_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        alu_load     = 1'b0;
        mul_load     = 1'b0;
        mul_start    = 1'b0;
        bus.in_ready = 1'b0;
        bus.wb_write = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (accept) begin
                    if (bus.op <= OP_SHL) begin
                        alu_load  = 1'b1;
                        state_nxt = WB;
                    end
`ifdef EXEC_MUL_EN
                    else if (bus.op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = MUL;
                    end
`endif
                end
            end
            MUL: begin
                if (mul_done) begin
                    mul_load  = 1'b1;
                    state_nxt = WB;
                end
            end
            WB: begin
                bus.wb_write = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-back registers load on the edge that enters WB and hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.wb_address <= '0;
            bus.wb_data    <= '0;
            flag_zero      <= 1'b0;
            flag_carry     <= 1'b0;
        end else if (alu_load) begin
            bus.wb_address <= bus.dest;
            bus.wb_data    <= alu_res[WIDTH-1:0];
            flag_zero      <= (alu_res[WIDTH-1:0] == '0);
            flag_carry     <= alu_res[WIDTH];
        end
`ifdef EXEC_MUL_EN
        else if (mul_load) begin
            bus.wb_address <= dest_q;
            bus.wb_data    <= mul_product[WIDTH-1:0];
            flag_zero      <= (mul_product[WIDTH-1:0] == '0);
            flag_carry     <= |mul_product[2*WIDTH-1:WIDTH];
        end
`endif
    end

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Directed, table-driven bench for regfile_exec_unit with hand-computed expected results.
module tb_regfile_exec_unit;

    logic clk;
    logic reset;
    logic busy;
    logic flag_zero;
    logic flag_carry;
    int   checks;
    int   errors;

    regfile_exec_unit_if #(.WIDTH(16), .AW(4)) bus ();

    regfile_exec_unit dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .busy       (busy),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  d;
        logic [15:0] data;
        logic        z;
        logic        c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; returns 1 ns after the accepting edge with operands scrambled.
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.value1   = a;
        bus.value2   = b;
        bus.dest     = d;
        step();
        bus.in_valid = 1'b0;
        bus.value1   = 16'hDEAD;
        bus.value2   = 16'hBEEF;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wb_write"},   32'(bus.wb_write),   32'd0);
        check({tag, " wb_address"}, 32'(bus.wb_address), 32'd0);
        check({tag, " wb_data"},    32'(bus.wb_data),    32'd0);
        check({tag, " in_ready"},   32'(bus.in_ready),   32'd1);
        check({tag, " busy"},       32'(busy),           32'd0);
        check({tag, " flag_zero"},  32'(flag_zero),      32'd0);
        check({tag, " flag_carry"}, 32'(flag_carry),     32'd0);
    endtask

    task automatic check_wb(input string tag, input vec_t v);
        check({tag, " wb_write"},   32'(bus.wb_write),   32'd1);
        check({tag, " wb_address"}, 32'(bus.wb_address), 32'(v.d));
        check({tag, " wb_data"},    32'(bus.wb_data),    32'(v.data));
        check({tag, " flag_zero"},  32'(flag_zero),      32'(v.z));
        check({tag, " flag_carry"}, 32'(flag_carry),     32'(v.c));
        check({tag, " in_ready"},   32'(bus.in_ready),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        vec_t mv   [3];
        vec_t v;
        int   pulses;
        int   acc_cycle;
        logic accepting;

        checks = 0;
        errors = 0;

        vecs[0]  = '{3'd0, 16'd10,    16'd7,     4'd3,  16'd17,    1'b0, 1'b0};
        vecs[1]  = '{3'd1, 16'd7,     16'd7,     4'd0,  16'd0,     1'b1, 1'b1};
        vecs[2]  = '{3'd0, 16'hFFFF,  16'h0001,  4'd1,  16'h0000,  1'b1, 1'b1};
        vecs[3]  = '{3'd1, 16'd5,     16'd7,     4'd2,  16'hFFFE,  1'b0, 1'b0};
        vecs[4]  = '{3'd2, 16'hF0F0,  16'hFF00,  4'd4,  16'hF000,  1'b0, 1'b0};
        vecs[5]  = '{3'd3, 16'hF0F0,  16'h0F00,  4'd5,  16'hFFF0,  1'b0, 1'b0};
        vecs[6]  = '{3'd4, 16'hFFFF,  16'h00FF,  4'd6,  16'hFF00,  1'b0, 1'b0};
        vecs[7]  = '{3'd5, 16'h0003,  16'h0014,  4'd7,  16'h0030,  1'b0, 1'b0};
        vecs[8]  = '{3'd5, 16'h8001,  16'h0001,  4'd15, 16'h0002,  1'b0, 1'b0};
        vecs[9]  = '{3'd2, 16'h00FF,  16'hFF00,  4'd8,  16'h0000,  1'b1, 1'b0};
        vecs[10] = '{3'd0, 16'h8000,  16'h8000,  4'd10, 16'h0000,  1'b1, 1'b1};

        mv[0] = '{3'd6, 16'd300,   16'd300,   4'd5,  16'h5F90, 1'b0, 1'b1};
        mv[1] = '{3'd6, 16'd3,     16'd5,     4'd9,  16'd15,   1'b0, 1'b0};
        mv[2] = '{3'd6, 16'h0100,  16'h0100,  4'd11, 16'h0000, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.value1   = '0;
        bus.value2   = '0;
        bus.dest     = '0;
        reset        = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        // ALU table: write-back in the cycle after accept, idle and holding the cycle after that.
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            issue(v.op, v.a, v.b, v.d);
            @(negedge clk);
            check_wb($sformatf("alu[%0d]", i), v);
            step();
            @(negedge clk);
            check($sformatf("alu[%0d] pulse end", i), 32'(bus.wb_write), 32'd0);
            check($sformatf("alu[%0d] ready", i),     32'(bus.in_ready), 32'd1);
            check($sformatf("alu[%0d] hold", i),      32'(bus.wb_data),  32'(v.data));
            step();
        end

        // Reserved opcode (and opcode 6 when multiply is absent): accepted, no effect.
`ifdef EXEC_MUL_EN
        for (int k = 0; k < 1; k++) begin
`else
        for (int k = 0; k < 2; k++) begin
`endif
            issue((k == 0) ? 3'd7 : 3'd6, 16'd1, 16'd2, 4'd9);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check($sformatf("rsv%0d wb_write", k), 32'(bus.wb_write),   32'd0);
                check($sformatf("rsv%0d in_ready", k), 32'(bus.in_ready),   32'd1);
                check($sformatf("rsv%0d busy", k),     32'(busy),           32'd0);
                check($sformatf("rsv%0d addr", k),     32'(bus.wb_address), 32'd10);
                check($sformatf("rsv%0d zero", k),     32'(flag_zero),      32'd1);
                check($sformatf("rsv%0d carry", k),    32'(flag_carry),     32'd1);
                step();
            end
        end

`ifdef EXEC_MUL_EN
        // Multiply: 16 busy MUL cycles then the WB cycle, operands scrambled after accept.
        for (int i = 0; i < 3; i++) begin
            v = mv[i];
            issue(v.op, v.a, v.b, v.d);
            for (int k = 1; k <= 17; k++) begin
                @(negedge clk);
                check($sformatf("mul[%0d] busy c%0d", i, k),  32'(busy),         32'd1);
                check($sformatf("mul[%0d] ready c%0d", i, k), 32'(bus.in_ready), 32'd0);
                if (k < 17) check($sformatf("mul[%0d] early c%0d", i, k), 32'(bus.wb_write), 32'd0);
                if (k < 17) step();
            end
            check_wb($sformatf("mul[%0d]", i), v);
            step();
            @(negedge clk);
            check($sformatf("mul[%0d] pulse end", i), 32'(bus.wb_write), 32'd0);
            check($sformatf("mul[%0d] ready", i),     32'(bus.in_ready), 32'd1);
            step();
        end

        // ADD held pending through a multiply: accepted on the first ready cycle, written once.
        issue(3'd6, 16'd300, 16'd300, 4'd5);
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.value1   = 16'd1;
        bus.value2   = 16'd2;
        bus.dest     = 4'd7;
        pulses       = 0;
        acc_cycle    = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.wb_write) begin
                pulses++;
                if (pulses == 1) begin
                    check("queue mul addr", 32'(bus.wb_address), 32'd5);
                    check("queue mul data", 32'(bus.wb_data),    32'h5F90);
                end else begin
                    check("queue add addr", 32'(bus.wb_address), 32'd7);
                    check("queue add data", 32'(bus.wb_data),    32'd3);
                end
            end
            accepting = bus.in_valid && bus.in_ready;
            if (accepting && acc_cycle < 0) acc_cycle = c;
            step();
            if (accepting) bus.in_valid = 1'b0;
        end
        check("queue pulses",       32'(pulses),    32'd2);
        check("queue accept cycle", 32'(acc_cycle), 32'd17);

        // Reset in the fifth cycle of a multiply aborts it entirely.
        issue(3'd6, 16'd300, 16'd300, 4'd5);
        repeat (4) step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mul abort");
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.wb_write) pulses++;
        end
        check("mul abort pulses", 32'(pulses), 32'd0);
        step();
        v = '{3'd0, 16'd1, 16'd1, 4'd2, 16'd2, 1'b0, 1'b0};
        issue(v.op, v.a, v.b, v.d);
        @(negedge clk);
        check_wb("post abort add", v);
        step();
`endif

        // Reset during the write-back cycle drops the pulse and clears all outputs.
        step();
        v = '{3'd0, 16'd4, 16'd4, 4'd6, 16'd8, 1'b0, 1'b0};
        issue(v.op, v.a, v.b, v.d);
        @(negedge clk);
        check_wb("wb reset pre", v);
        reset = 1'b0;
        #1;
        check_reset_outputs("wb reset");
        @(negedge clk);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("wb reset after", 32'(bus.wb_write), 32'd0);
        check("wb reset ready", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_exec_unit.md
Name: regfile_exec_unit

Overview:
- Execute stage that sits directly downstream of the 16-entry x 16-bit register file's read ports.
- Consumes the two read values (value1/value2) with an opcode and a destination address.
- Computes a 16-bit result and drives the register file's write port (write/address/data) for write-back.
- Single-cycle logic/arithmetic ops; multiply is a multi-cycle shift-add.

Parameters:
- WIDTH, 16, datapath width; must match the register file word width.
- AW, 4, register address width (16 entries).
- MUL_STEPS, WIDTH, shift-add iterations per multiply.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  3  opcode (see Behaviour).
- value1  in  WIDTH  operand A, from register file read port 1.
- value2  in  WIDTH  operand B, from register file read port 2.
- dest  in  AW  write-back register address.
- wb_write  out  1  write strobe to register file, one-cycle pulse.
- wb_address  out  AW  write-back address.
- wb_data  out  WIDTH  write-back data.
- busy  out  1  high in any state other than IDLE.
- flag_zero  out  1  last written result == 0.
- flag_carry  out  1  carry/overflow of last written result.

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=1; wb_write=0; wb_address=0; wb_data=0; busy=0; flag_zero=0; flag_carry=0; multiplier registers cleared.
- Opcodes:
  - 0 ADD: A+B; carry = bit WIDTH of the sum.
  - 1 SUB: A-B computed as A+~B+1; carry = bit WIDTH (1 means no borrow).
  - 2 AND, 3 OR, 4 XOR: bitwise; carry=0.
  - 5 SHL: A<<B[3:0]; carry=0.
  - 6 MUL: low WIDTH bits of A*B; carry=1 iff the high WIDTH bits of the product are nonzero.
  - 7 reserved: no write-back.
- States and transitions:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) at edge N latches op, A, B and dest.
    - ALU op (0-5): go to WB at edge N; result is registered at the same edge.
    - MUL: go to MUL at edge N.
    - Op 7: stay in IDLE; no output change.
  - MUL: one shift-add iteration per edge, using a 2*WIDTH accumulator and a step counter 0..MUL_STEPS-1. After the last iteration (edge N+MUL_STEPS), go to WB.
  - WB: wb_write=1 for exactly one cycle, with wb_address/wb_data valid and flags updated at the same edge. Return to IDLE at the next edge.
- Latency from accept edge N:
  - ALU op: wb_write high in the cycle following edge N.
  - MUL: wb_write high in the cycle following edge N+16.
- Throughput:
  - ALU op: one op per 2 cycles.
  - MUL: one op per 18 cycles.
- in_ready=0 in MUL and WB. in_valid asserted while in_ready=0 is ignored; the requester must hold the request until accepted.
- Operands are latched at accept. Changes on value1/value2 after accept have no effect.
- wb_address and wb_data hold their last values when wb_write=0. Flags change only in WB.
- dest=0 is a normal, writable register.
- Reset asserted mid-MUL or in WB aborts the operation: no write pulse, all outputs take reset values.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: opcode 6 performs the multi-cycle multiply described above.
- Undefined: MUL state and datapath are not built; opcode 6 behaves as reserved (accepted, no write-back, stays IDLE); busy is never high for opcode 6.

Decomposition:
- Package exec_pkg holds:
  - opcode constants OP_ADD..OP_RSV;
  - state encoding IDLE/MUL/WB;
  - WIDTH/AW defaults.
- One sub-module, exec_mul_seq: sequential shift-add multiplier with start/done, a 2*WIDTH product and a step counter. Instantiated only under EXEC_MUL_EN.

Test Plan:
- ADD, A=10, B=7, dest=3 -> next cycle wb_write=1, wb_address=3, wb_data=17, flag_zero=0, flag_carry=0; wb_write=0 the cycle after.
- SUB, A=7, B=7, dest=0 -> wb_data=0, flag_zero=1, flag_carry=1; then ADD 0xFFFF+1 -> wb_data=0, flag_carry=1.
- MUL, A=300, B=300, dest=5 -> busy and in_ready=0 for 17 cycles; wb_write at cycle N+17; wb_data=24464 (0x5F90), flag_carry=1.
- in_valid held high with new ops during MUL -> none accepted until in_ready=1; the queued ADD then writes exactly once.
- reset driven 0 at cycle 5 of MUL -> no wb_write pulse, all outputs at reset values; after release, in_ready=1 and an ADD completes normally.
- Op 7 and, with EXEC_MUL_EN undefined, op 6 -> accepted, wb_write stays 0, flags unchanged, in_ready stays 1.
